// File: rtl/t1_vfu_pkg.sv
// Shared types for the VFU issue path: the per-slot request record and its derived widths.
package t1_vfu_pkg;

  // Width of the slot tag stamped into each issued request.
  localparam int unsigned TAG_W = 2;

  // One lane-slot request to the VFU. tag is the last field, so it occupies the
  // lowest TAG_W bits of the packed vector.
  typedef struct packed {
    logic [32:0] src_0;
    logic [32:0] src_1;
    logic [32:0] src_2;
    logic [32:0] src_3;
    logic [3:0]  opcode;
    logic [3:0]  mask;
    logic [3:0]  execute_mask;
    logic        sign0;
    logic        sign;
    logic        reverse;
    logic        average;
    logic        saturate;
    logic [1:0]  vxrm;
    logic [1:0]  v_sew;
    logic [19:0] shifter_size;
    logic        rem;
    logic [1:0]  execute_index;
    logic [10:0] pop_init;
    logic [4:0]  group_index;
    logic [4:0]  lane_index;
    logic        mask_type;
    logic        narrow;
    logic [3:0]  unit_selet;
    logic        float_mul;
    logic [2:0]  rounding_mode;
    logic [TAG_W-1:0] tag;
  } slot_request_t;

  localparam int unsigned REQ_W = $bits(slot_request_t);

  // Returns the request with its tag replaced by the issuing slot index.
  function automatic slot_request_t stamp_tag(slot_request_t req, logic [TAG_W-1:0] tag);
    slot_request_t r;
    r     = req;
    r.tag = tag;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] grant_idx_o,
  output logic                 any_req_o
);

  localparam int unsigned IdxW = $clog2(N);

  // Scan from the farthest candidate back to ptr so the nearest valid slot wins last.
  always_comb begin
    logic [IdxW-1:0] cand;
    cand        = '0;
    grant_idx_o = '0;
    any_req_o   = |req_i;
    for (int k = N - 1; k >= 0; k--) begin
      // N is a power of two, so the add wraps naturally.
      cand = ptr_i + IdxW'(k);
      if (req_i[cand]) begin
        grant_idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/vfu_slot_issue_arbiter.sv
// Round-robin issue arbiter sharing one VFU request port among lane slots, with a
// single registered output stage and a credit counter bounding in-flight requests.
module vfu_slot_issue_arbiter
  import t1_vfu_pkg::*;
#(
  parameter int unsigned SLOTS        = 4,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [SLOTS-1:0]       in_valid_i,
  output logic [SLOTS-1:0]       in_ready_o,
  input  logic [SLOTS*REQ_W-1:0] in_bits_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [REQ_W-1:0]       out_bits_o,
  input  logic                   resp_valid_i,
  output logic [2:0]             inflight_o,
  output logic                   err_underflow_o
);

  localparam int unsigned IdxW        = $clog2(SLOTS);
  localparam logic [2:0]  MaxInflight = 3'(MAX_INFLIGHT);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  slot_request_t   out_bits_q, out_bits_d;
  logic [2:0]      inflight_q, inflight_d;
  logic            err_q, err_d;

  logic [IdxW-1:0] grant_idx;
  logic            any_req;
  logic            can_load;
  logic            load;
  logic            fire;
  slot_request_t   req_sel;

  rr_arbiter #(
    .N(SLOTS)
  ) u_rr_arbiter (
    .req_i       (in_valid_i),
    .ptr_i       (ptr_q),
    .grant_idx_o (grant_idx),
    .any_req_o   (any_req)
  );

  // Load decision: output slot free (or draining now) and a credit available (or returning now).
  always_comb begin
    can_load = (!out_valid_q || out_ready_i) && ((inflight_q < MaxInflight) || resp_valid_i);
    // rst_ni gating keeps in_ready low for the whole asynchronous reset window.
    load     = rst_ni && any_req && can_load;
    fire     = out_valid_q && out_ready_i;
    req_sel  = slot_request_t'(in_bits_i[grant_idx*REQ_W +: REQ_W]);
  end

  // Accept only the granted slot, and only when a load actually happens.
  always_comb begin
    in_ready_o = '0;
    if (load) begin
      in_ready_o[grant_idx] = 1'b1;
    end
  end

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_bits_d  = out_bits_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_bits_d  = stamp_tag(req_sel, TAG_W'(grant_idx));
      ptr_d       = grant_idx + IdxW'(1);
    end else if (fire) begin
      out_valid_d = 1'b0;
    end
  end

  // Credit counter: consumed at load, returned by a response; both together cancel out.
  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q;
    if (load && !resp_valid_i) begin
      inflight_d = inflight_q + 3'd1;
    end else if (!load && resp_valid_i) begin
      if (inflight_q != 3'd0) begin
        inflight_d = inflight_q - 3'd1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      ptr_q       <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_bits_q  <= out_bits_d;
      ptr_q       <= ptr_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o     = out_valid_q;
  assign out_bits_o      = out_bits_q;
  assign inflight_o      = inflight_q;
  assign err_underflow_o = err_q;

endmodule

// File: tb/tb_vfu_slot_issue_arbiter.sv
// Self-checking bench for vfu_slot_issue_arbiter: directed scenarios plus a random run,
// all checked against a queue-based behavioural model.
module tb_vfu_slot_issue_arbiter;
  import t1_vfu_pkg::*;

  localparam int unsigned SLOTS = 4;
  localparam int unsigned MAXI  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [SLOTS-1:0]       in_valid;
  logic [SLOTS-1:0]       in_ready;
  logic [SLOTS*REQ_W-1:0] in_bits;
  logic                   out_valid;
  logic                   out_ready;
  logic [REQ_W-1:0]       out_bits;
  logic                   resp_valid;
  logic [2:0]             inflight;
  logic                   err_underflow;

  vfu_slot_issue_arbiter #(
    .SLOTS        (SLOTS),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_bits_i       (in_bits),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_bits_o      (out_bits),
    .resp_valid_i    (resp_valid),
    .inflight_o      (inflight),
    .err_underflow_o (err_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: pointer, held output entry, list of outstanding request tags, sticky error.
  int               m_ptr;
  bit               m_ovalid;
  logic [REQ_W-1:0] m_obits;
  int               m_outstanding[$];
  bit               m_err;

  int tests_run;
  int tests_failed;

  function automatic logic [SLOTS*REQ_W-1:0] rand_bits();
    logic [SLOTS*REQ_W-1:0] v;
    for (int i = 0; i < int'(SLOTS * REQ_W); i++) v[i] = 1'($urandom());
    return v;
  endfunction

  task automatic model_reset();
    m_ptr    = 0;
    m_ovalid = 1'b0;
    m_obits  = '0;
    m_outstanding.delete();
    m_err    = 1'b0;
  endtask

  task automatic do_reset();
    in_valid   = '0;
    out_ready  = 1'b0;
    resp_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare DUT against the model mid-cycle, advance the model.
  task automatic step(input logic [SLOTS-1:0] iv, input logic ordy, input logic rv);
    int               g;
    bit               any;
    bit               can_load;
    bit               ld;
    logic [SLOTS-1:0] exp_ready;
    logic [REQ_W-1:0] slice;
    in_valid   = iv;
    out_ready  = ordy;
    resp_valid = rv;
    in_bits    = rand_bits();
    @(negedge clk);
    any = 1'b0;
    g   = 0;
    for (int off = 0; off < int'(SLOTS); off++) begin
      int s;
      s = (m_ptr + off) % SLOTS;
      if (!any && iv[s]) begin
        any = 1'b1;
        g   = s;
      end
    end
    can_load  = (!m_ovalid || ordy) && ((m_outstanding.size() < int'(MAXI)) || rv);
    ld        = any && can_load;
    exp_ready = '0;
    if (ld) exp_ready[g] = 1'b1;

    tests_run++;
    if (in_ready !== exp_ready) begin
      tests_failed++;
      $display("FAIL step.in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_ready);
    end
    tests_run++;
    if (out_valid !== m_ovalid) begin
      tests_failed++;
      $display("FAIL step.out_valid t=%0t got=%b exp=%b", $time, out_valid, m_ovalid);
    end
    if (m_ovalid) begin
      tests_run++;
      if (out_bits !== m_obits) begin
        tests_failed++;
        $display("FAIL step.out_bits t=%0t got=%h exp=%h", $time, out_bits, m_obits);
      end
    end
    tests_run++;
    if (inflight !== 3'(m_outstanding.size())) begin
      tests_failed++;
      $display("FAIL step.inflight t=%0t got=%0d exp=%0d", $time, inflight,
               m_outstanding.size());
    end
    tests_run++;
    if (err_underflow !== m_err) begin
      tests_failed++;
      $display("FAIL step.err_underflow t=%0t got=%b exp=%b", $time, err_underflow, m_err);
    end

    if (ld) begin
      slice              = in_bits[g*REQ_W +: REQ_W];
      slice[TAG_W-1:0]   = TAG_W'(g);
      m_obits            = slice;
      m_ovalid           = 1'b1;
      m_ptr              = (g + 1) % SLOTS;
      m_outstanding.push_back(g);
    end else if (m_ovalid && ordy) begin
      m_ovalid = 1'b0;
    end
    if (rv) begin
      if (m_outstanding.size() > 0) void'(m_outstanding.pop_front());
      else m_err = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = '1;
    out_ready  = 1'b1;
    resp_valid = 1'b1;
    in_bits    = rand_bits();
    #3;
    tests_run++;
    if (in_ready !== '0) begin
      tests_failed++;
      $display("FAIL reset.in_ready got=%b exp=0", in_ready);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset.out_valid got=%b exp=0", out_valid);
    end
    tests_run++;
    if (out_bits !== '0) begin
      tests_failed++;
      $display("FAIL reset.out_bits got=%h exp=0", out_bits);
    end
    tests_run++;
    if (inflight !== 3'd0 || err_underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset.counters inflight=%0d err=%b exp=0/0", inflight, err_underflow);
    end
    // Clock edges while reset is held must not load anything.
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== '0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset.held in_ready=%b out_valid=%b exp=0/0", in_ready, out_valid);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int exp_tag[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      step('1, 1'b1, 1'b1);
      tests_run++;
      if (out_valid !== 1'b1 || out_bits[TAG_W-1:0] !== TAG_W'(exp_tag[i])) begin
        tests_failed++;
        $display("FAIL rr.tag[%0d] valid=%b tag=%0d exp=1/%0d", i, out_valid,
                 out_bits[TAG_W-1:0], exp_tag[i]);
      end
    end
  endtask

  task automatic test_single_slot();
    // Pointer is 1 here; issuing slot 2 moves it to 3, then slot 2 alone must wrap around.
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b1);
    tests_run++;
    if (out_valid !== 1'b1 || out_bits[TAG_W-1:0] !== 2'd2) begin
      tests_failed++;
      $display("FAIL single.tag valid=%b tag=%0d exp=1/2", out_valid, out_bits[TAG_W-1:0]);
    end
    step('1, 1'b1, 1'b1);
    tests_run++;
    if (out_bits[TAG_W-1:0] !== 2'd3) begin
      tests_failed++;
      $display("FAIL single.ptr_after tag=%0d exp=3", out_bits[TAG_W-1:0]);
    end
    step('0, 1'b1, 1'b1);
  endtask

  task automatic test_stall();
    logic [REQ_W-1:0] held;
    step('1, 1'b1, 1'b0);
    held = out_bits;
    for (int i = 0; i < 5; i++) begin
      step('1, 1'b0, 1'b0);
      tests_run++;
      if (out_valid !== 1'b1 || out_bits !== held) begin
        tests_failed++;
        $display("FAIL stall.hold[%0d] valid=%b bits=%h exp=1/%h", i, out_valid, out_bits, held);
      end
    end
    step('1, 1'b1, 1'b1);
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall.fire_load out_valid=%b exp=1", out_valid);
    end
    step('0, 1'b1, 1'b1);
  endtask

  task automatic test_credits();
    do_reset();
    step('1, 1'b1, 1'b0);
    step('1, 1'b1, 1'b0);
    tests_run++;
    if (inflight !== 3'd2) begin
      tests_failed++;
      $display("FAIL credits.full inflight=%0d exp=2", inflight);
    end
    step('1, 1'b1, 1'b0);
    tests_run++;
    if (out_valid !== 1'b0 || inflight !== 3'd2) begin
      tests_failed++;
      $display("FAIL credits.blocked out_valid=%b inflight=%0d exp=0/2", out_valid, inflight);
    end
    step('1, 1'b1, 1'b1);
    tests_run++;
    if (out_valid !== 1'b1 || inflight !== 3'd2) begin
      tests_failed++;
      $display("FAIL credits.swap out_valid=%b inflight=%0d exp=1/2", out_valid, inflight);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step('0, 1'b1, 1'b1);
    tests_run++;
    if (err_underflow !== 1'b1 || inflight !== 3'd0) begin
      tests_failed++;
      $display("FAIL underflow.set err=%b inflight=%0d exp=1/0", err_underflow, inflight);
    end
    for (int i = 0; i < 3; i++) step('0, 1'b1, 1'b0);
    step('1, 1'b1, 1'b0);
    tests_run++;
    if (err_underflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow.sticky err=%b exp=1", err_underflow);
    end
    do_reset();
    tests_run++;
    if (err_underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL underflow.clear err=%b exp=0", err_underflow);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step('1, 1'b0, 1'b0);
    step('1, 1'b1, 1'b0);
    // Now at posedge+1: out_valid=1, inflight=2. A returning credit would allow a load.
    in_valid   = '1;
    out_ready  = 1'b1;
    resp_valid = 1'b1;
    #1;
    tests_run++;
    if (!$onehot(in_ready) || out_valid !== 1'b1 || inflight !== 3'd2) begin
      tests_failed++;
      $display("FAIL areset.pre in_ready=%b out_valid=%b inflight=%0d exp=onehot/1/2",
               in_ready, out_valid, inflight);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || inflight !== 3'd0 || in_ready !== '0 || out_bits !== '0) begin
      tests_failed++;
      $display("FAIL areset.now out_valid=%b inflight=%0d in_ready=%b bits_zero=%b exp=0/0/0/1",
               out_valid, inflight, in_ready, out_bits == '0);
    end
    model_reset();
    in_valid   = '0;
    resp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(SLOTS'($urandom()), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    in_valid     = '0;
    out_ready    = 1'b0;
    resp_valid   = 1'b0;
    in_bits      = '0;
    rst_n        = 1'b0;
    model_reset();
    test_reset();
    test_round_robin();
    test_single_slot();
    test_stall();
    test_credits();
    test_underflow();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
